// File: rtl/ifns_pkg.sv
// Shared constants for the 4-bit/5-bit lane decoder: widths, lane weights and legal codeword table.
// Legality helpers are only referenced when IFNS_CHK_EN is defined.
package ifns_pkg;

  localparam int CW_W      = 5;
  localparam int DATA_W    = 4;
  localparam int NUM_LEGAL = 16;
  localparam int CNT_W     = 8;

  localparam logic [DATA_W-1:0] WT_D5 = 4'd8;
  localparam logic [DATA_W-1:0] WT_D4 = 4'd3;
  localparam logic [DATA_W-1:0] WT_D3 = 4'd2;
  localparam logic [DATA_W-1:0] WT_D2 = 4'd1;
  localparam logic [DATA_W-1:0] WT_D1 = 4'd1;

  // Entry v sits at bits [5v+4:5v]; it is the unique legal codeword whose weighted sum is v.
  localparam logic [NUM_LEGAL*CW_W-1:0] LEGAL_CW_TBL = {
    5'b11111, 5'b11110, 5'b11100, 5'b11001,
    5'b11000, 5'b10011, 5'b10001, 5'b10000,
    5'b01111, 5'b01110, 5'b01100, 5'b00111,
    5'b00110, 5'b00011, 5'b00001, 5'b00000
  };

  // The sum is a bijection on legal words, so one table lookup by value settles legality.
  function automatic logic cw_is_legal(input logic [CW_W-1:0] cw, input logic [DATA_W-1:0] value);
    return (LEGAL_CW_TBL[int'(value)*CW_W +: CW_W] == cw);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/ifns_4di_dec_core.sv
// Single-lane combinational decode of a 5-bit codeword into its 4-bit weighted sum.
// With IFNS_CHK_EN defined it also reports whether the codeword is outside the legal set.
module ifns_4di_dec_core
  import ifns_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
`ifdef IFNS_CHK_EN
  output logic              illegal,
`endif
  output logic [DATA_W-1:0] value
);

  // Weighted sum of codeword bits d5..d1; the maximum is 15 so 4 bits never overflow
  always_comb begin
    value = ({DATA_W{cw[4]}} & WT_D5)
          + ({DATA_W{cw[3]}} & WT_D4)
          + ({DATA_W{cw[2]}} & WT_D3)
          + ({DATA_W{cw[1]}} & WT_D2)
          + ({DATA_W{cw[0]}} & WT_D1);
  end

`ifdef IFNS_CHK_EN
  assign illegal = !cw_is_legal(cw, value);
`endif

endmodule

// File: rtl/ifns_4di_rx_decoder.sv
// Two-stage ready/valid decoder for LANES parallel 5-bit codewords into 4-bit values.
// Optional IFNS_CHK_EN adds per-lane illegal-codeword flags and a saturating error-beat counter.
module ifns_4di_rx_decoder
  import ifns_pkg::*;
#(
  parameter int LANES = 4
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cw_valid,
  input  logic [CW_W*LANES-1:0]   cw_data,
  output logic                    cw_ready,
  output logic                    data_valid,
  output logic [DATA_W*LANES-1:0] data,
  input  logic                    data_ready,
  output logic [LANES-1:0]        cw_err,
  output logic [CNT_W-1:0]        err_cnt
);

  logic                    s1_valid_r;
  logic [CW_W*LANES-1:0]   s1_data_r;
  logic                    s2_valid_r;
  logic [DATA_W*LANES-1:0] s2_data_r;
  logic [DATA_W*LANES-1:0] dec_data_s;
  logic                    s1_load_s;
  logic                    s2_free_s;
  logic                    s2_load_s;

  assign s2_free_s = !s2_valid_r || data_ready;
  assign s2_load_s = s1_valid_r && s2_free_s;
  assign cw_ready  = !s1_valid_r || !s2_valid_r || data_ready;
  assign s1_load_s = cw_valid && cw_ready;

  assign data_valid = s2_valid_r;
  assign data       = s2_data_r;

`ifdef IFNS_CHK_EN
  logic [LANES-1:0]        dec_err_s;
  logic [LANES-1:0]        s2_err_r;
  logic [CNT_W-1:0]        err_cnt_r;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ifns_4di_dec_core u_core (
      .cw      (s1_data_r[i*CW_W +: CW_W]),
`ifdef IFNS_CHK_EN
      .illegal (dec_err_s[i]),
`endif
      .value   (dec_data_s[i*DATA_W +: DATA_W])
    );
  end

  // Input stage: take an accepted beat, or empty once the beat has moved on to S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= cw_data;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Output stage: load decoded lanes when free, otherwise hold for the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= '0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_data_r  <= dec_data_s;
    end else if (s2_free_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

`ifdef IFNS_CHK_EN
  // Error flags travel with the decoded word; the counter steps once per delivered bad word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_err_r  <= '0;
      err_cnt_r <= '0;
    end else begin
      if (s2_load_s) begin
        s2_err_r <= dec_err_s;
      end else begin
        s2_err_r <= s2_err_r;
      end
      if (s2_valid_r && data_ready && (|s2_err_r)) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign cw_err  = s2_err_r;
  assign err_cnt = err_cnt_r;
`else
  assign cw_err  = '0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ifns_4di_rx_decoder.sv
// Randomized scoreboard bench for ifns_4di_rx_decoder (LANES=4 plus a LANES=1 shadow instance).
`timescale 1ns/1ps
module tb_ifns_4di_rx_decoder;

  localparam int LANES = 4;
`ifdef IFNS_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [4:0] LEGAL [16] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00110, 5'b00111, 5'b01100, 5'b01110, 5'b01111,
    5'b10000, 5'b10001, 5'b10011, 5'b11000, 5'b11001, 5'b11100, 5'b11110, 5'b11111};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cw_valid = 1'b0;
  logic                 data_ready = 1'b0;
  logic [5*LANES-1:0]   cw_data = '0;
  logic                 cw_ready, data_valid;
  logic [4*LANES-1:0]   data;
  logic [LANES-1:0]     cw_err;
  logic [7:0]           err_cnt;
  logic                 cw_ready1, data_valid1;
  logic [3:0]           data1;
  logic [0:0]           cw_err1;
  logic [7:0]           err_cnt1;

  always #5 clk = ~clk;

  ifns_4di_rx_decoder #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .cw_valid(cw_valid), .cw_data(cw_data), .cw_ready(cw_ready),
    .data_valid(data_valid), .data(data), .data_ready(data_ready), .cw_err(cw_err), .err_cnt(err_cnt));

  ifns_4di_rx_decoder #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cw_valid(cw_valid), .cw_data(cw_data[4:0]), .cw_ready(cw_ready1),
    .data_valid(data_valid1), .data(data1), .data_ready(data_ready), .cw_err(cw_err1), .err_cnt(err_cnt1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: weighted sum and membership in the legal list
  function automatic int lane_val(input logic [4:0] c);
    return 8*int'(c[4]) + 3*int'(c[3]) + 2*int'(c[2]) + int'(c[1]) + int'(c[0]);
  endfunction

  function automatic bit lane_legal(input logic [4:0] c);
    for (int k = 0; k < 16; k++) if (LEGAL[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  typedef struct {
    logic [4*LANES-1:0] d;
    logic [LANES-1:0]   e;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_acc = 0;
  int   err_exp = 0;
  int   err1_exp = 0;
  bit   lat_mode = 1'b0;
  bit   prev_hold = 1'b0;
  logic [4*LANES-1:0] prev_data;
  logic [LANES-1:0]   prev_err;

  // Scoreboard: sampled on the falling edge, between active edges
  always @(negedge clk) begin
    exp_t e;
    int v;
    logic [4:0] c;
    cyc++;
    if (!rst_n) begin
      prev_hold = 1'b0;
      err_exp   = 0;
      err1_exp  = 0;
    end else begin
      check_eq("cw_ready", cw_ready, (data_ready || q.size() < 2));
      check_eq("err_cnt", err_cnt, err_exp);
      check_eq("err_cnt1", err_cnt1, err1_exp);
      if (prev_hold) begin
        check_eq("hold_valid", data_valid, 1);
        check_eq("hold_data", data, prev_data);
        check_eq("hold_err", cw_err, prev_err);
      end
      if (data_valid && data_ready) begin
        if (q.size() == 0) begin
          check_eq("unexpected_word", data_valid, 0);
        end else begin
          e = q.pop_front();
          check_eq("data", data, e.d);
          check_eq("cw_err", cw_err, e.e);
          check_eq("data_valid1", data_valid1, 1);
          check_eq("data1", data1, e.d[3:0]);
          check_eq("cw_err1", cw_err1, e.e[0]);
          if (lat_mode) check_eq("latency", cyc - e.cyc, 2);
          if (e.e != '0 && err_exp < 255) err_exp++;
          if (e.e[0] && err1_exp < 255) err1_exp++;
        end
      end
      prev_hold = data_valid && !data_ready;
      prev_data = data;
      prev_err  = cw_err;
      if (cw_valid && cw_ready) begin
        for (int i = 0; i < LANES; i++) begin
          c = cw_data[5*i +: 5];
          v = lane_val(c);
          e.d[4*i +: 4] = v[3:0];
          e.e[i] = CHK_EN && !lane_legal(c);
        end
        e.cyc = cyc;
        q.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    cw_valid   = 1'b0;
    data_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check_eq("drain_empty", q.size(), 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    check_eq("rst_data_valid", data_valid, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_cw_err", cw_err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_cw_ready", cw_ready, 1);
    rst_n = 1'b1;
    tick();

    // All legal codewords on lane 0, back to back, with latency check
    data_ready = 1'b1;
    lat_mode   = 1'b1;
    for (int v = 0; v < 16; v++) begin
      cw_valid = 1'b1;
      cw_data  = {15'd0, LEGAL[v]};
      tick();
    end
    drain();
    lat_mode = 1'b0;

    // Stall: data_ready low for 5 cycles with continuous beats
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cw_valid = 1'b1;
      cw_data  = 20'($urandom);
      @(negedge clk);
      check_eq("stall_ready", cw_ready, (i < 2));
      tick();
    end
    check_eq("stall_inflight", q.size(), 2);
    drain();

    // Two illegal lanes in one beat
    check_eq("err_cnt_pre", err_cnt, 0);
    cw_data  = {5'b00000, 5'b10101, 5'b00010, 5'b00000};
    cw_valid = 1'b1;
    data_ready = 1'b0;
    tick();
    cw_valid = 1'b0;
    n = 0;
    while (!data_valid && n < 10) begin
      tick();
      n++;
    end
    check_eq("ill_lane1", data[7:4], 1);
    check_eq("ill_lane2", data[11:8], 11);
    check_eq("ill_cw_err", cw_err, CHK_EN ? 4'b0110 : 4'b0000);
    data_ready = 1'b1;
    tick();
    check_eq("err_cnt_post", err_cnt, CHK_EN ? 1 : 0);
    drain();

    // 300 illegal beats saturate the counter
    for (int i = 0; i < 300; i++) begin
      cw_valid = 1'b1;
      cw_data  = {15'($urandom), 5'b00010};
      tick();
    end
    drain();
    check_eq("err_cnt_sat", err_cnt, CHK_EN ? 255 : 0);
    check_eq("err_cnt1_sat", err_cnt1, CHK_EN ? 255 : 0);

    // Reset with both stages full
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cw_valid = 1'b1;
      cw_data  = 20'($urandom);
      tick();
    end
    cw_valid = 1'b0;
    @(negedge clk);
    check_eq("full_inflight", q.size(), 2);
    check_eq("full_valid", data_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", data_valid, 0);
    check_eq("mid_rst_ready", cw_ready, 1);
    check_eq("mid_rst_err_cnt", err_cnt, 0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    data_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("post_rst_idle", data_valid, 0);
    end

    // Random traffic, 10k beats
    n_acc = 0;
    n = 0;
    while (n_acc < 10000 && n < 40000) begin
      cw_valid   = 1'($urandom);
      data_ready = 1'($urandom);
      cw_data    = 20'($urandom);
      tick();
      n++;
    end
    check_eq("rand_beats_done", (n_acc >= 10000), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
